// File: rtl/stopwatch_time_counter_pkg.sv
// Shared constants for the stopwatch time counter: digit widths, digit moduli, slice indices.
// Pure definitions; no latency, no backpressure.
package stopwatch_pkg;
    localparam int BCD_W  = 4;
    localparam int DIGITS = 6;

    localparam logic [BCD_W-1:0] HUN_MAX   = 4'd9;
    localparam logic [BCD_W-1:0] DEC_MAX   = HUN_MAX;
    localparam logic [BCD_W-1:0] SEC_T_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN_T_MAX = 4'd5;

    localparam logic [DIGITS*BCD_W-1:0] TIME_MAX = 24'h595999;

    // Digit positions inside cnt_bcd/disp_bcd, LSB digit first
    localparam int DIG_HUN_U = 0;
    localparam int DIG_HUN_T = 1;
    localparam int DIG_SEC_U = 2;
    localparam int DIG_SEC_T = 3;
    localparam int DIG_MIN_U = 4;
    localparam int DIG_MIN_T = 5;

    typedef logic [DIGITS*BCD_W-1:0] time_bcd_t;

    function automatic logic [BCD_W-1:0] digit_of(time_bcd_t t, int idx);
        return t[idx*BCD_W +: BCD_W];
    endfunction
endpackage

// File: rtl/stopwatch_time_counter_if.sv
// Control levels in from the stopwatch state machine, live/latched time and pulses out.
// Level signals only; no handshake, no backpressure.
interface stopwatch_time_counter_if;
    import stopwatch_pkg::*;

    logic      clr;
    logic      Time_ce;
    logic      enable_lc;
    time_bcd_t cnt_bcd;
    time_bcd_t disp_bcd;
    logic      tick;
    logic      ovf;

    modport master (
        output clr, Time_ce, enable_lc,
        input  cnt_bcd, disp_bcd, tick, ovf
    );

    modport slave (
        input  clr, Time_ce, enable_lc,
        output cnt_bcd, disp_bcd, tick, ovf
    );
endinterface

// File: rtl/stopwatch_time_counter_bcd_digit_cnt.sv
// One BCD digit counting 0..MAX; carry is combinational so a whole cascade settles in one edge.
// Advances one step per cycle with inc=1; clr wins over inc.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 4'd9
) (
    input  logic             count_clock,
    input  logic             count_reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);
    logic [BCD_W-1:0] r_q;

    always_ff @(posedge count_clock or posedge count_reset) begin
        if (count_reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= (r_q == MAX) ? '0 : r_q + 1'b1;
        end
    end

    assign q     = r_q;
    assign carry = inc && (r_q == MAX);
endmodule

// File: rtl/stopwatch_time_counter.sv
// Prescaler + MM:SS.hh BCD cascade + display latch; tick/ovf registered one cycle after the advance, disp_bcd lags by one.
// No backpressure; STOPWATCH_SATURATE_EN selects hold-at-59:59.99 with sticky ovf instead of wrap.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int PRE_W   = 16
) (
    input  logic                     count_clock,
    input  logic                     count_reset,
    stopwatch_time_counter_if.slave  bus
);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic             r_tick;
    logic             r_ovf;
    time_bcd_t        r_disp;
    time_bcd_t        w_cnt;
    logic [DIGITS-1:0] w_carry;
    logic             w_adv;
    logic             w_inc;

    assign w_adv = bus.Time_ce && !bus.clr && (r_pre == PRE_LAST);

    // Prescaler holds while Time_ce=0 so a pause keeps the partial period
    always_ff @(posedge count_clock or posedge count_reset) begin
        if (count_reset) begin
            r_pre <= '0;
        end else if (bus.clr) begin
            r_pre <= '0;
        end else if (bus.Time_ce) begin
            r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
        end
    end

`ifdef STOPWATCH_SATURATE_EN
    logic w_at_max;
    assign w_at_max = (w_cnt == TIME_MAX);
    assign w_inc    = w_adv && !w_at_max;
`else
    assign w_inc = w_adv;
`endif

    bcd_digit_cnt #(.MAX(HUN_MAX)) u_hun_u (
        .count_clock(count_clock), .count_reset(count_reset), .clr(bus.clr), .inc(w_inc),
        .q(w_cnt[DIG_HUN_U*BCD_W +: BCD_W]), .carry(w_carry[DIG_HUN_U]));
    bcd_digit_cnt #(.MAX(HUN_MAX)) u_hun_t (
        .count_clock(count_clock), .count_reset(count_reset), .clr(bus.clr), .inc(w_carry[DIG_HUN_U]),
        .q(w_cnt[DIG_HUN_T*BCD_W +: BCD_W]), .carry(w_carry[DIG_HUN_T]));
    bcd_digit_cnt #(.MAX(DEC_MAX)) u_sec_u (
        .count_clock(count_clock), .count_reset(count_reset), .clr(bus.clr), .inc(w_carry[DIG_HUN_T]),
        .q(w_cnt[DIG_SEC_U*BCD_W +: BCD_W]), .carry(w_carry[DIG_SEC_U]));
    bcd_digit_cnt #(.MAX(SEC_T_MAX)) u_sec_t (
        .count_clock(count_clock), .count_reset(count_reset), .clr(bus.clr), .inc(w_carry[DIG_SEC_U]),
        .q(w_cnt[DIG_SEC_T*BCD_W +: BCD_W]), .carry(w_carry[DIG_SEC_T]));
    bcd_digit_cnt #(.MAX(DEC_MAX)) u_min_u (
        .count_clock(count_clock), .count_reset(count_reset), .clr(bus.clr), .inc(w_carry[DIG_SEC_T]),
        .q(w_cnt[DIG_MIN_U*BCD_W +: BCD_W]), .carry(w_carry[DIG_MIN_U]));
    bcd_digit_cnt #(.MAX(MIN_T_MAX)) u_min_t (
        .count_clock(count_clock), .count_reset(count_reset), .clr(bus.clr), .inc(w_carry[DIG_MIN_U]),
        .q(w_cnt[DIG_MIN_T*BCD_W +: BCD_W]), .carry(w_carry[DIG_MIN_T]));

    always_ff @(posedge count_clock or posedge count_reset) begin
        if (count_reset) begin
            r_tick <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_tick <= w_inc;
`ifdef STOPWATCH_SATURATE_EN
            r_ovf  <= bus.clr ? 1'b0 : (r_ovf | (w_adv && w_at_max));
`else
            // Top digit carrying out means the whole count just wrapped
            r_ovf  <= w_carry[DIG_MIN_T];
`endif
        end
    end

    always_ff @(posedge count_clock or posedge count_reset) begin
        if (count_reset) begin
            r_disp <= '0;
        end else if (bus.enable_lc) begin
            r_disp <= w_cnt;
        end
    end

    assign bus.cnt_bcd  = w_cnt;
    assign bus.disp_bcd = r_disp;
    assign bus.tick     = r_tick;
    assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: directed scenarios plus random control levels against an elapsed-hundredths model.
module tb_stopwatch_time_counter;
    import stopwatch_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int TOTAL   = 360000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    stopwatch_time_counter_if sw_if();

    stopwatch_time_counter #(.CLK_DIV(CLK_DIV), .PRE_W(16)) dut (
        .count_clock(clk),
        .count_reset(rst),
        .bus(sw_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ticks;

    int   m_pre, m_hund, m_disp;
    logic m_tick, m_ovf;
    logic [23:0] pre_b;

    function automatic logic [23:0] to_bcd(int h);
        int mm, ss, hh;
        mm = h / 6000;
        ss = (h / 100) % 60;
        hh = h % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(hh / 10), 4'(hh % 10)};
    endfunction

    task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m_pre = 0; m_hund = 0; m_disp = 0; m_tick = 1'b0; m_ovf = 1'b0;
    endtask

    // Reference: time as elapsed hundredths, inputs as sampled on the edge
    task automatic model_edge();
        int prev;
        prev = m_hund;
        if (rst) return;
        if (sw_if.clr) begin
            m_pre = 0; m_hund = 0; m_tick = 1'b0; m_ovf = 1'b0;
        end else if (sw_if.Time_ce) begin
            m_pre++;
            m_tick = 1'b0;
`ifndef STOPWATCH_SATURATE_EN
            m_ovf = 1'b0;
`endif
            if (m_pre == CLK_DIV) begin
                m_pre = 0;
                if (m_hund == TOTAL - 1) begin
`ifdef STOPWATCH_SATURATE_EN
                    m_ovf = 1'b1;
`else
                    m_hund = 0; m_tick = 1'b1; m_ovf = 1'b1;
`endif
                end else begin
                    m_hund++;
                    m_tick = 1'b1;
                end
            end
        end else begin
            m_tick = 1'b0;
`ifndef STOPWATCH_SATURATE_EN
            m_ovf = 1'b0;
`endif
        end
        if (sw_if.enable_lc) m_disp = prev;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cnt",  sw_if.cnt_bcd,  to_bcd(m_hund));
        chk("disp", sw_if.disp_bcd, to_bcd(m_disp));
        chk("tick", {23'b0, sw_if.tick}, {23'b0, m_tick});
        chk("ovf",  {23'b0, sw_if.ovf},  {23'b0, m_ovf});
    endtask

    task automatic drive(logic c, logic ce, logic en);
        sw_if.clr = c; sw_if.Time_ce = ce; sw_if.enable_lc = en;
    endtask

    task automatic run(int n, logic c, logic ce, logic en);
        drive(c, ce, en);
        repeat (n) step();
    endtask

    // Deposit a count directly into the digit registers between edges
    task automatic preload(int h);
        pre_b = to_bcd(h);
        force dut.u_hun_u.r_q = pre_b[3:0];
        force dut.u_hun_t.r_q = pre_b[7:4];
        force dut.u_sec_u.r_q = pre_b[11:8];
        force dut.u_sec_t.r_q = pre_b[15:12];
        force dut.u_min_u.r_q = pre_b[19:16];
        force dut.u_min_t.r_q = pre_b[23:20];
        #1;
        release dut.u_hun_u.r_q;
        release dut.u_hun_t.r_q;
        release dut.u_sec_u.r_q;
        release dut.u_sec_t.r_q;
        release dut.u_min_u.r_q;
        release dut.u_min_t.r_q;
        m_hund = h;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        model_zero();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt",  sw_if.cnt_bcd,  24'h0);
        chk("rst_disp", sw_if.disp_bcd, 24'h0);
        chk("rst_tick", {23'b0, sw_if.tick}, 24'h0);
        chk("rst_ovf",  {23'b0, sw_if.ovf},  24'h0);
        rst = 1'b0;

        // Basic counting: two ticks in 8 enabled edges
        ticks = 0;
        drive(1'b0, 1'b1, 1'b1);
        repeat (8) begin step(); ticks += int'(sw_if.tick); end
        chk("p1_cnt",   sw_if.cnt_bcd, 24'h000002);
        chk("p1_ticks", 24'(ticks), 24'd2);
        step();
        chk("p1_disp",  sw_if.disp_bcd, 24'h000002);

        // Pause keeps the partial prescaler period
        run(1, 1'b1, 1'b0, 1'b1);
        ticks = 0;
        drive(1'b0, 1'b1, 1'b1); repeat (2)  begin step(); ticks += int'(sw_if.tick); end
        drive(1'b0, 1'b0, 1'b1); repeat (10) begin step(); ticks += int'(sw_if.tick); end
        drive(1'b0, 1'b1, 1'b1); repeat (2)  begin step(); ticks += int'(sw_if.tick); end
        step();
        chk("p2_ticks", 24'(ticks), 24'd1);
        chk("p2_cnt",   sw_if.cnt_bcd, 24'h000001);

        // Full cascades in one edge
        run(1, 1'b1, 1'b0, 1'b1);
        preload(999);
        run(4, 1'b0, 1'b1, 1'b1);
        chk("p3_cascade_sec", sw_if.cnt_bcd, 24'h001000);
        run(1, 1'b1, 1'b0, 1'b1);
        preload(59999);
        run(4, 1'b0, 1'b1, 1'b1);
        chk("p3_cascade_min", sw_if.cnt_bcd, 24'h100000);

        // Maximum count
        run(1, 1'b1, 1'b0, 1'b1);
        preload(TOTAL - 1);
        run(4, 1'b0, 1'b1, 1'b1);
`ifdef STOPWATCH_SATURATE_EN
        chk("p4_sat_cnt", sw_if.cnt_bcd, 24'h595999);
        chk("p4_sat_ovf", {23'b0, sw_if.ovf}, 24'd1);
        run(4, 1'b0, 1'b1, 1'b1);
        chk("p4_sat_ovf_sticky", {23'b0, sw_if.ovf}, 24'd1);
        run(1, 1'b1, 1'b0, 1'b1);
        chk("p4_sat_ovf_clr", {23'b0, sw_if.ovf}, 24'd0);
`else
        chk("p4_wrap_cnt", sw_if.cnt_bcd, 24'h000000);
        chk("p4_wrap_ovf", {23'b0, sw_if.ovf}, 24'd1);
        step();
        chk("p4_ovf_pulse", {23'b0, sw_if.ovf}, 24'd0);
`endif

        // Display lock
        run(1, 1'b1, 1'b0, 1'b1);
        preload(1234);
        run(1, 1'b0, 1'b0, 1'b1);
        run(12, 1'b0, 1'b1, 1'b0);
        chk("p5_disp_frozen", sw_if.disp_bcd, 24'h001234);
        chk("p5_cnt_live",    sw_if.cnt_bcd,  24'h001237);
        run(1, 1'b0, 1'b1, 1'b1);
        chk("p5_disp_catchup", sw_if.disp_bcd, 24'h001237);
        run(1, 1'b1, 1'b0, 1'b0);
        chk("p5_disp_hold_clr", sw_if.disp_bcd, 24'h001237);

        // clr beats Time_ce; async reset mid-prescale
        preload(500);
        run(1, 1'b1, 1'b1, 1'b1);
        chk("p6_clr_cnt",  sw_if.cnt_bcd, 24'h0);
        chk("p6_clr_tick", {23'b0, sw_if.tick}, 24'd0);
        run(6, 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_zero();
        chk("p6_arst_cnt",  sw_if.cnt_bcd,  24'h0);
        chk("p6_arst_disp", sw_if.disp_bcd, 24'h0);
        chk("p6_arst_tick", {23'b0, sw_if.tick}, 24'd0);
        chk("p6_arst_ovf",  {23'b0, sw_if.ovf},  24'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(3, 1'b0, 1'b1, 1'b1);
        chk("p6_post_rst_no_tick", sw_if.cnt_bcd, 24'h0);
        run(1, 1'b0, 1'b1, 1'b1);
        chk("p6_post_rst_first", sw_if.cnt_bcd, 24'h000001);

        // Random control levels
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom % 64 == 0), 1'($urandom % 4 != 0), 1'($urandom % 8 != 0));
            step();
        end
        preload(TOTAL - 10);
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom % 256 == 0), 1'($urandom % 8 != 0), 1'($urandom % 4 != 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
Responder for the stopwatch control state machine: consumes its clr, Time_ce and enable_lc levels and produces the running stopwatch time in BCD. It contains a prescaler, a cascaded BCD time counter MM:SS.hh and a display latch feeding the 7-segment scan driver. It sits between the control state machine and the display path, in the same clock domain as the state machine.

Parameters:
CLK_DIV, 100, count_clock cycles per 0.01 s tick (10 kHz clock -> 100 Hz); legal range 2..65535.
PRE_W, 16, prescaler width; must satisfy 2**PRE_W >= CLK_DIV.

Ports:
count_clock  input  1  block clock, rising edge; same clock as the state machine.
count_reset  input  1  asynchronous reset, active-high.
clr  input  1  counter clear, active-high level from the state machine.
Time_ce  input  1  count enable, active-high level.
enable_lc  input  1  display latch enable; 1 = display follows count, 0 = hold (lock).
cnt_bcd  output  24  live count {min_t, min_u, sec_t, sec_u, hun_t, hun_u}, 4 bits per digit, MSB first.
disp_bcd  output  24  latched display value, same format as cnt_bcd.
tick  output  1  one-cycle pulse on the cycle the count advances.
ovf  output  1  one-cycle pulse when the count wraps 59:59.99 -> 00:00.00.

Behaviour:
- count_reset (async): prescaler, all digits, disp_bcd, tick and ovf go to 0 immediately.
- Priority on each rising edge is count_reset > clr > Time_ce.
- clr=1:
  - Prescaler and all digits are cleared synchronously; tick=0, ovf=0.
  - Time_ce is ignored while clr=1.
- Prescaler:
  - Time_ce=1 and clr=0: pre increments; at pre==CLK_DIV-1 it wraps to 0 and the counter advances on that same edge.
  - Time_ce=0: pre holds. Pause/resume therefore keeps the partial period, with no lost or extra time.
- tick is registered. It is 1 in the cycle after the edge where the counter advanced.
- Counter cascade:
  - hun_u 0..9 carries into hun_t 0..9.
  - hun_t carries into sec_u 0..9; sec_u carries into sec_t 0..5.
  - sec_t carries into min_u 0..9; min_u carries into min_t 0..5.
  - All carries resolve in the same edge; there is no ripple latency.
  - Digits never hold values outside their range. Max value = 59:59.99 = 0x595999.
- Wrap: advancing from 0x595999 gives 0x000000. ovf pulses for one cycle, aligned with tick.
- Display latch:
  - enable_lc=1: disp_bcd <= cnt_bcd (registered), so disp_bcd lags cnt_bcd by exactly one cycle.
  - enable_lc=0: disp_bcd holds its value. This holds even if clr pulses, or if the count advances or wraps.
  - Returning enable_lc to 1: disp_bcd catches up to the live count on the next edge.
- Reset mid-operation (async assert at any phase): all state is 0. The first enabled edge after release counts pre 0->1.
- clr and Time_ce are state-machine outputs on count_clock and need no synchronisation. Inputs are sampled only on rising edges.

Optional Feature:
STOPWATCH_SATURATE_EN:
- Defined: the counter saturates at 0x595999 and never wraps; ovf is a sticky flag, set on the first attempted advance past the maximum and cleared only by clr or count_reset; tick stops once saturated.
- Undefined: wrap-around with a one-cycle ovf pulse, as described in Behaviour.

Decomposition:
- Package stopwatch_pkg:
  - BCD_W=4.
  - Digit moduli HUN_MAX=9, SEC_T_MAX=5, MIN_T_MAX=5.
  - TIME_MAX=24'h595999.
  - Digit-index constants for slicing cnt_bcd/disp_bcd.
- Sub-module bcd_digit_cnt (parameter MAX): one digit with inputs clr, inc and outputs q[3:0], carry (= inc && q==MAX). It is instantiated six times in the cascade. Prescaler and display latch stay in the top module.

Test Plan:
1. CLK_DIV=4; assert count_reset, release; Time_ce=1, clr=0, enable_lc=1 for 8 edges -> cnt_bcd=0x000002, tick seen twice, disp_bcd=0x000002 one cycle later.
2. CLK_DIV=4; Time_ce=1 for 2 edges, Time_ce=0 for 10 edges, Time_ce=1 for 2 edges -> exactly one tick in total, cnt_bcd=0x000001 (prescaler held during pause).
3. Force count to 0x000999 then one tick -> 0x001000; count 0x095999 then tick -> 0x100000 (full cascade in one edge).
4. Count at 0x595999, one tick -> cnt_bcd=0x000000, ovf=1 for exactly one cycle. With STOPWATCH_SATURATE_EN: stays 0x595999, ovf stays 1 until clr.
5. Running at 0x001234: enable_lc=0 -> disp_bcd frozen at 0x001234 while cnt_bcd advances; enable_lc=1 -> disp_bcd equals previous-cycle cnt_bcd on the next edge.
6. clr=1 and Time_ce=1 together at 0x000500 -> cnt_bcd=0x000000, no tick. Async count_reset mid-prescale -> all outputs 0 before the next clock edge.
